pipe_adder: RTL and testbench

Parametrised, pipelined add/subtract unit for the MIPS datapath. It splits a WIDTH-bit operation into WIDTH/LANE ripple-carry stages, with one register stage per lane, so that long carry chains do not limit the clock. Operands enter and results leave through valid/ready handshakes. The block feeds the ALU result mux and the branch/address adders.

---
 rtl/pipe_adder_pkg.sv | 18 +
 rtl/adder_lane.sv | 30 +++
 rtl/pipe_adder.sv | 145 ++++++++++++++
 tb/tb_pipe_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: operation encoding, default geometry and the geometry
// legality check shared by the pipelined add/subtract unit.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_LANE  = 8;

    // WIDTH must split into a whole number of non-empty lanes.
    function automatic bit shape_ok(int unsigned width, int unsigned lane);
        return (lane != 0) && (width >= lane) && ((width % lane) == 0);
    endfunction

endpackage

// File: rtl/adder_lane.sv
// adder_lane: LANE-bit ripple-carry adder made of full-adder cells.
// c_msb is the carry into the top bit, used for signed overflow.
module adder_lane #(
    parameter int unsigned LANE = 8
) (
    input  logic [LANE-1:0] a,
    input  logic [LANE-1:0] b,
    input  logic            cin,
    output logic [LANE-1:0] sum,
    output logic            cout,
    output logic            c_msb
);

    logic [LANE:0] carry;

    // Full-adder cells chained LSB to MSB.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < LANE; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = carry[LANE];
    assign c_msb = carry[LANE-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract, one LANE-bit ripple stage per cycle.
// Operands are skew-delayed lane by lane; finished sum lanes ride along
// with the operation so all lanes leave together. Stage STAGES-1 is the
// output register.
// Optional macro PIPE_ADDER_FLAGS_EN builds the ovf/zero/neg flag registers;
// without it those outputs are tied low.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LANE  = DEF_LANE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int unsigned STAGES = WIDTH / LANE;
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'({LANE{1'b1}});

    if (!shape_ok(WIDTH, LANE)) begin : g_bad_shape
        $error("pipe_adder: WIDTH must be a non-zero multiple of LANE");
    end

    op_e  op;
    logic advance;

    // Per-stage inputs (from the port for stage 0, else from the previous stage).
    logic [WIDTH-1:0]  a_src  [STAGES];
    logic [WIDTH-1:0]  b_src  [STAGES];
    logic [WIDTH-1:0]  s_src  [STAGES];
    logic [WIDTH-1:0]  s_next [STAGES];
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] v_src;

    // Per-stage registers.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    logic [LANE-1:0]   lane_sum [STAGES];
    logic [STAGES-1:0] lane_cout;
    logic [STAGES-1:0] lane_cmsb;

    assign op       = op_e'(in_sub);
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtract is A + ~B + 1; carry-in only matters for add.
            assign a_src[k] = in_a;
            assign b_src[k] = (op == OP_SUB) ? ~in_b : in_b;
            assign c_src[k] = (op == OP_SUB) ? 1'b1 : in_cin;
            assign s_src[k] = '0;
            assign v_src[k] = in_valid;
        end else begin : g_next
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign c_src[k] = c_q[k-1];
            assign s_src[k] = s_q[k-1];
            assign v_src[k] = v_q[k-1];
        end

        adder_lane #(.LANE(LANE)) u_lane (
            .a     (a_src[k][k*LANE +: LANE]),
            .b     (b_src[k][k*LANE +: LANE]),
            .cin   (c_src[k]),
            .sum   (lane_sum[k]),
            .cout  (lane_cout[k]),
            .c_msb (lane_cmsb[k])
        );

        assign s_next[k] = (s_src[k] & ~(LOW_MASK << (k*LANE)))
                         | (WIDTH'(lane_sum[k]) << (k*LANE));
    end

    // Whole pipeline shifts together on advance; bubbles move like beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_next[k];
            end
            c_q <= lane_cout;
            v_q <= v_src;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];

`ifdef PIPE_ADDER_FLAGS_EN
    logic ovf_q, zero_q, neg_q;

    // Flags are taken from the final lane and registered with the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance) begin
            ovf_q  <= lane_cout[STAGES-1] ^ lane_cmsb[STAGES-1];
            zero_q <= (s_next[STAGES-1] == '0);
            neg_q  <= s_next[STAGES-1][WIDTH-1];
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
    assign out_neg  = neg_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = ^lane_cmsb;

    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (32/8 main instance plus a
// 4/1 instance for the single-bit-lane cases).
module tb_pipe_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned L  = 8;
    localparam int unsigned ST = W / L;
`ifdef PIPE_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic          out_valid, out_ready, out_cout, out_ovf, out_zero, out_neg;

    logic          s_in_valid, s_in_ready, s_in_cin, s_in_sub;
    logic [3:0]    s_in_a, s_in_b, s_out_sum;
    logic          s_out_valid, s_out_ready, s_out_cout, s_out_ovf, s_out_zero, s_out_neg;

    pipe_adder #(.WIDTH(W), .LANE(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
    );

    pipe_adder #(.WIDTH(4), .LANE(1)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_cout(s_out_cout),
        .out_ovf(s_out_ovf), .out_zero(s_out_zero), .out_neg(s_out_neg)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        int unsigned issue;
        int unsigned snap;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned stalls = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    bit          rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(int unsigned w, logic [31:0] a, logic [31:0] b,
                                   logic cin, logic sub);
        exp_t e;
        longint unsigned m    = (64'd1 << w) - 1;
        longint unsigned au   = {32'd0, a} & m;
        longint unsigned bu   = {32'd0, b} & m;
        longint          half = 64'sd1 << (w - 1);
        longint          sa, sb, st;
        longint unsigned tot;
        sa = (au >= half) ? longint'(au) - 2 * half : longint'(au);
        sb = (bu >= half) ? longint'(bu) - 2 * half : longint'(bu);
        if (sub) begin
            tot    = (au - bu) & m;
            e.cout = (au >= bu);
            st     = sa - sb;
        end else begin
            tot    = au + bu + {63'd0, cin};
            e.cout = ((tot >> w) & 1) != 0;
            st     = sa + sb + {63'd0, cin};
        end
        e.sum   = 32'(tot & m);
        e.ovf   = FLAGS && ((st >= half) || (st < -half));
        e.zero  = FLAGS && ((tot & m) == 0);
        e.neg   = FLAGS && (((tot >> (w - 1)) & 1) != 0);
        e.issue = 0;
        e.snap  = 0;
        return e;
    endfunction

    // Monitor: peeks the head while a result is shown, pops on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                check("result_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q[0];
                    check("sum",  out_sum,  mon_e.sum);
                    check("cout", out_cout, mon_e.cout);
                    check("ovf",  out_ovf,  mon_e.ovf);
                    check("zero", out_zero, mon_e.zero);
                    check("neg",  out_neg,  mon_e.neg);
                    if (out_ready) begin
                        check("latency", cyc - mon_e.issue, ST + stalls - mon_e.snap);
                        void'(exp_q.pop_front());
                    end
                end
                if (!out_ready) stalls++;
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        exp_t e;
        bit   accepted = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                e = model(W, a, b, cin, sub);
                e.issue = cyc;
                e.snap  = stalls;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            if (accepted) break;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        check("in_accept", accepted, 1'b1);
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic small_test(input logic [3:0] a, input logic [3:0] b, input logic cin,
                              input logic [3:0] xsum, input logic xcout, input logic xovf);
        int unsigned c0;
        int unsigned waited = 0;
        s_in_a = a; s_in_b = b; s_in_cin = cin; s_in_valid = 1'b1;
        @(negedge clk);
        check("small_in_ready", s_in_ready, 1'b1);
        c0 = cyc;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        do begin
            @(negedge clk);
            waited++;
        end while (!s_out_valid && waited < 20);
        check("small_latency", cyc - c0, 4);
        check("small_sum",  s_out_sum,  xsum);
        check("small_cout", s_out_cout, xcout);
        check("small_ovf",  s_out_ovf,  FLAGS && xovf);
        check("small_zero", s_out_zero, FLAGS && (xsum == 4'd0));
        check("small_neg",  s_out_neg,  FLAGS && xsum[3]);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_in_sub = 1'b0;
        s_out_ready = 1'b1;
        #3;
        check("rst_valid", out_valid, 1'b0);
        check("rst_sum",   out_sum,   '0);
        check("rst_cout",  out_cout,  1'b0);
        check("rst_flags", {out_ovf, out_zero, out_neg}, 3'b000);
        check("rst_small_valid", s_out_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-bit lanes: four stages across a 4-bit word.
        small_test(4'b0110, 4'b0110, 1'b0, 4'b1100, 1'b0, 1'b1);
        small_test(4'b1100, 4'b1110, 1'b1, 4'b1011, 1'b1, 1'b0);

        // Directed subtract and overflow cases.
        issue(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
        issue(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        drain();

        // Eight back-to-back beats.
        for (int n = 0; n < 8; n++) issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Backpressure: three stalled cycles with a result showing.
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        issue(32'h0F0F_0F0F, 32'h0000_00F1, 1'b1, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check("bp_valid", out_valid, 1'b1);
        check("bp_in_ready", in_ready, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        drain();

        // Random beats with random gaps and random consumer stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        drain();

        // Reset with one result showing and two more in flight.
        issue(32'hAAAA_0001, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'hAAAA_0002, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'hAAAA_0003, 32'h0000_0001, 1'b0, 1'b0);
        idle(1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_sum",   out_sum,   '0);
        check("midrst_cout",  out_cout,  1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h0000_0040, 32'h0000_0002, 1'b0, 1'b1);
        issue(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
